// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, ALU operation codes
// and controller state encoding.
package acc_ctrl_pkg;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDI = 4'h1;
  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_SUB = 4'h3;
  localparam logic [3:0] OPC_AND = 4'h4;
  localparam logic [3:0] OPC_OR  = 4'h5;
  localparam logic [3:0] OPC_XOR = 4'h6;
  localparam logic [3:0] OPC_JMP = 4'h7;
  localparam logic [3:0] OPC_JZ  = 4'h8;
  localparam logic [3:0] OPC_JNZ = 4'h9;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
`ifdef ACC_CTRL_STEP_EN
    ,
    S_WAIT   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/acc_ctrl_dec.sv
// Combinational opcode decoder: ALU operation plus instruction class flags.
module acc_ctrl_dec
  import acc_ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output alu_op_t             alu_op,
  output logic                is_alu,
  output logic                is_jmp,
  output logic                is_jz,
  output logic                is_jnz,
  output logic                is_hlt,
  output logic                illegal
);

  always_comb begin
    alu_op  = ALU_PASS;
    is_alu  = 1'b0;
    is_jmp  = 1'b0;
    is_jz   = 1'b0;
    is_jnz  = 1'b0;
    is_hlt  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_WIDTH'(OPC_NOP): ;
      OP_WIDTH'(OPC_LDI): begin alu_op = ALU_PASS; is_alu = 1'b1; end
      OP_WIDTH'(OPC_ADD): begin alu_op = ALU_ADD;  is_alu = 1'b1; end
      OP_WIDTH'(OPC_SUB): begin alu_op = ALU_SUB;  is_alu = 1'b1; end
      OP_WIDTH'(OPC_AND): begin alu_op = ALU_AND;  is_alu = 1'b1; end
      OP_WIDTH'(OPC_OR):  begin alu_op = ALU_OR;   is_alu = 1'b1; end
      OP_WIDTH'(OPC_XOR): begin alu_op = ALU_XOR;  is_alu = 1'b1; end
      OP_WIDTH'(OPC_JMP): is_jmp = 1'b1;
      OP_WIDTH'(OPC_JZ):  is_jz  = 1'b1;
      OP_WIDTH'(OPC_JNZ): is_jnz = 1'b1;
      OP_WIDTH'(OPC_HLT): is_hlt = 1'b1;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_ctrl.sv
// Instruction sequencer for the accumulator datapath: fetch, decode, execute, pc.
// Optional single-step mode (WAIT state and step input) with ACC_CTRL_STEP_EN.
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int OP_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int CNTR_WIDTH    = 8,
  parameter int COMBINED_DATA = OP_WIDTH + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
`ifdef ACC_CTRL_STEP_EN
  input  logic                     step,
`endif
  output logic                     imem_req,
  output logic [CNTR_WIDTH-1:0]    imem_addr,
  input  logic                     imem_ack,
  input  logic [COMBINED_DATA-1:0] imem_data,
  input  logic                     acc_zero,
  output logic [2:0]               alu_op,
  output logic [DATA_WIDTH-1:0]    alu_b,
  output logic                     acc_we,
  output logic [CNTR_WIDTH-1:0]    pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     err
);

  state_t                state, state_next;
  logic [OP_WIDTH-1:0]   ir_op;
  logic [ADDR_WIDTH-1:0] ir_target;
  alu_op_t               alu_op_q;

  logic [OP_WIDTH-1:0]   dec_opcode;
  alu_op_t               dec_alu_op;
  logic                  dec_is_alu, dec_is_jmp, dec_is_jz, dec_is_jnz;
  logic                  dec_is_hlt, dec_illegal;
  logic                  capture, jump_taken;

  assign capture = (state == S_FETCH) && imem_ack;

  // The decoder looks at the incoming word while fetching so alu_op is already
  // registered by the DECODE cycle; afterwards it decodes the held opcode.
  assign dec_opcode = (state == S_FETCH) ? imem_data[COMBINED_DATA-1 -: OP_WIDTH] : ir_op;

  acc_ctrl_dec #(
    .OP_WIDTH(OP_WIDTH)
  ) u_dec (
    .opcode (dec_opcode),
    .alu_op (dec_alu_op),
    .is_alu (dec_is_alu),
    .is_jmp (dec_is_jmp),
    .is_jz  (dec_is_jz),
    .is_jnz (dec_is_jnz),
    .is_hlt (dec_is_hlt),
    .illegal(dec_illegal)
  );

  assign jump_taken = dec_is_jmp || (dec_is_jz && acc_zero) || (dec_is_jnz && !acc_zero);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  if (imem_ack) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (dec_is_hlt)
          state_next = S_HALT;
        else begin
`ifdef ACC_CTRL_STEP_EN
          state_next = S_WAIT;
`else
          state_next = run ? S_FETCH : S_IDLE;
`endif
        end
      end
      S_HALT:   state_next = S_HALT;
`ifdef ACC_CTRL_STEP_EN
      S_WAIT: begin
        if (!run)
          state_next = S_IDLE;
        else if (step)
          state_next = S_FETCH;
      end
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir_op     <= '0;
      ir_target <= '0;
      alu_op_q  <= ALU_PASS;
      alu_b     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        ir_op     <= imem_data[COMBINED_DATA-1 -: OP_WIDTH];
        ir_target <= imem_data[DATA_WIDTH +: ADDR_WIDTH];
        alu_op_q  <= dec_alu_op;
        alu_b     <= imem_data[DATA_WIDTH-1:0];
      end
      // HLT leaves pc on the halting instruction; illegal opcodes advance like NOP.
      if (state == S_EXEC) begin
        if (dec_illegal)
          err <= 1'b1;
        if (jump_taken)
          pc <= CNTR_WIDTH'(ir_target);
        else if (!dec_is_hlt)
          pc <= pc + CNTR_WIDTH'(1);
      end
    end
  end

  assign alu_op    = alu_op_q;
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign acc_we    = (state == S_EXEC) && dec_is_alu;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted    = (state == S_HALT);

endmodule
